// File: rtl/manual_step_pkg.sv
// Shared types and default timing for the manual step clock generator.
// Defaults assume the 10 MHz system clock.
package manual_step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 200_000;     // 20 ms
    localparam int unsigned DEF_MANUAL_HIGH     = 5_000_000;   // 0.5 s
    localparam int unsigned DEF_REPEAT_DELAY    = 10_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;  // 2 s

    // One spare bit so a counter can hold its terminal value without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; reset loads a
// caller-supplied idle level so a released key never looks pressed.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make both flops sample the pre-edge values,
    // giving two real register stages instead of one collapsed wire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/manual_step_gen.sv
// Manual step clock: debounces a push button and emits one fixed-width
// manual_clock high phase plus a one-cycle strobe per step, with auto-repeat.
module manual_step_gen
    import manual_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned MANUAL_HIGH     = DEF_MANUAL_HIGH,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        in_clock,
    input  logic        reset_n,
    input  logic        key_raw,
    input  logic        enable,
    input  logic        repeat_en,
    output logic        manual_clock,
    output logic        step_pulse,
    output logic        key_held,
    output logic [15:0] step_count
);

    localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HI_W    = cnt_width(MANUAL_HIGH);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = cnt_width(REP_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST        = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HI_W-1:0]  HI_LAST         = HI_W'(MANUAL_HIGH - 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    if (REPEAT_PERIOD <= MANUAL_HIGH || DEBOUNCE_CYCLES == 0 || MANUAL_HIGH == 0 ||
        REPEAT_DELAY == 0) begin : g_bad_timing
        $error("manual_step_gen: REPEAT_PERIOD must exceed MANUAL_HIGH and all counts be non-zero");
    end

    logic             key_sync;
    logic             key_s;
    state_t           state;
    state_t           next_state;
    logic [DEB_W-1:0] deb_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [HI_W-1:0]  hi_cnt;
    logic [15:0]      step_cnt_q;
    logic             deb_inc;
    logic             accept;
    logic             in_held;
    logic             rep_first;
    logic             repeat_due;
    logic             issue;

    sync_2ff #(.WIDTH(1)) u_key_sync (
        .clk     (in_clock),
        .rst_n   (reset_n),
        .rst_val (BTN_ACTIVE_LOW),
        .d       (key_raw),
        .q       (key_sync)
    );

    assign key_s = key_sync ^ BTN_ACTIVE_LOW;

    always_ff @(posedge in_clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every output of this block is given a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        deb_inc    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) next_state = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!key_s) begin
                    next_state = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    next_state = HELD;
                    accept     = 1'b1;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            HELD: begin
                if (!key_s) next_state = DEB_RELEASE;
            end
            DEB_RELEASE: begin
                if (key_s) begin
                    next_state = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    next_state = IDLE;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!enable) begin
            next_state = IDLE;
            deb_inc    = 1'b0;
            accept     = 1'b0;
        end
    end

    assign in_held    = (state == HELD) || (state == DEB_RELEASE);
    assign repeat_due = enable && repeat_en && in_held &&
                        (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST));
    assign issue      = accept || repeat_due;
    assign key_held   = in_held;
    assign step_count = step_cnt_q;

    // Debounce counter only runs on consecutive qualifying samples; the first
    // repeat uses REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_ff @(posedge in_clock) begin
        if (!reset_n) begin
            deb_cnt   <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            deb_cnt <= deb_inc ? deb_cnt + 1'b1 : '0;
            if (accept) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (repeat_due) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (repeat_en && in_held) begin
                rep_cnt <= rep_cnt + 1'b1;
            end else begin
                rep_cnt <= '0;
            end
        end
    end

    // A running high phase always completes; a step landing inside it is
    // counted and strobed but does not stretch the phase.
    always_ff @(posedge in_clock) begin
        if (!reset_n) begin
            step_pulse   <= 1'b0;
            manual_clock <= 1'b0;
            hi_cnt       <= '0;
            step_cnt_q   <= '0;
        end else begin
            step_pulse <= issue;
            if (issue) step_cnt_q <= step_cnt_q + 16'd1;
            if (issue && !manual_clock) begin
                manual_clock <= 1'b1;
                hi_cnt       <= '0;
            end else if (manual_clock) begin
                if (hi_cnt == HI_LAST) manual_clock <= 1'b0;
                else                   hi_cnt       <= hi_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_manual_step_gen.sv
// Scoreboard bench for manual_step_gen with shortened timing constants.
module tb_manual_step_gen;

    localparam int unsigned DEB = 4;
    localparam int unsigned MH  = 3;
    localparam int unsigned RD  = 12;
    localparam int unsigned RP  = 8;

    logic        in_clock  = 1'b0;
    logic        reset_n   = 1'b0;
    logic        key_raw   = 1'b0;
    logic        enable    = 1'b0;
    logic        repeat_en = 1'b0;
    logic        manual_clock;
    logic        step_pulse;
    logic        key_held;
    logic [15:0] step_count;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    logic        rst_q     = 1'b0;
    bit          mon_en    = 1'b0;
    int          mc_left   = 0;
    int          exp_q[$];
    logic [15:0] exp_count = 16'd0;

    manual_step_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .MANUAL_HIGH     (MH),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .in_clock     (in_clock),
        .reset_n      (reset_n),
        .key_raw      (key_raw),
        .enable       (enable),
        .repeat_en    (repeat_en),
        .manual_clock (manual_clock),
        .step_pulse   (step_pulse),
        .key_held     (key_held),
        .step_count   (step_count)
    );

    always #50 in_clock = ~in_clock;

    always @(posedge in_clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset_n;
    end

    // Scoreboard: expected step cycles come from the stimulus; the manual_clock
    // model is derived from those expectations and from the sampled reset.
    always @(negedge in_clock) begin
        if (mon_en) begin
            bit exp_step;
            if (!rst_q) mc_left = 0;
            exp_step = (exp_q.size() > 0) && (exp_q[0] == cyc);
            if (exp_step) begin
                void'(exp_q.pop_front());
                if (mc_left == 0) mc_left = MH;
            end
            checks++;
            if (step_pulse !== exp_step) begin
                errors++;
                $display("FAIL step_pulse @cyc %0d: got %b expected %b", cyc, step_pulse, exp_step);
            end
            checks++;
            if (manual_clock !== (mc_left > 0)) begin
                errors++;
                $display("FAIL manual_clock @cyc %0d: got %b expected %b", cyc, manual_clock, (mc_left > 0));
            end
            if (mc_left > 0) mc_left--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge in_clock);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic expect_step(input int at);
        exp_q.push_back(at);
        exp_count = exp_count + 16'd1;
    endtask

    // Called #1 after an edge with the block idle: first sampling edge is cyc+1.
    task automatic press(output int s);
        s       = cyc + 3 + DEB;
        key_raw = 1'b0;
        expect_step(s);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        key_raw   = 1'b0;
        enable    = 1'b1;
        repeat_en = 1'b0;
        tick(2);
        checks++;
        if (manual_clock !== 1'b0) begin errors++; $display("FAIL reset_manual_clock: got %b expected 0", manual_clock); end
        checks++;
        if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse: got %b expected 0", step_pulse); end
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
        checks++;
        if (step_count !== 16'd0) begin errors++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
        reset_n   = 1'b1;
        key_raw   = 1'b1;
        exp_count = 16'd0;
        mon_en    = 1'b1;
        tick(50);
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL reset_idle_count: got %0d expected %0d", step_count, exp_count); end
    endtask

    task automatic test_clean_press();
        int s;
        press(s);
        wait_cyc(s + 2);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL clean_key_held: got %b expected 1", key_held); end
        tick(18);
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL clean_count: got %0d expected %0d", step_count, exp_count); end
        key_raw = 1'b1;
        tick(3 + DEB + 2);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL clean_release: got %b expected 0", key_held); end
    endtask

    task automatic test_bounce();
        int s;
        for (int i = 0; i < 15; i++) begin
            key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_raw = 1'b1;
        tick(8);
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL bounce_press_count: got %0d expected %0d", step_count, exp_count); end
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_press_held: got %b expected 0", key_held); end
        press(s);
        wait_cyc(s + 2);
        for (int i = 0; i < 10; i++) begin
            key_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(2);
        end
        tick(2);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL bounce_release_held: got %b expected 1", key_held); end
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL bounce_release_count: got %0d expected %0d", step_count, exp_count); end
        key_raw = 1'b1;
        tick(3 + DEB + 2);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_final_release: got %b expected 0", key_held); end
    endtask

    task automatic test_auto_repeat();
        int a;
        logic [15:0] start;
        start     = exp_count;
        repeat_en = 1'b1;
        press(a);
        expect_step(a + RD);
        expect_step(a + RD + RP);
        expect_step(a + RD + 2 * RP);
        expect_step(a + RD + 3 * RP);
        wait_cyc(a + RD + 3 * RP);
        key_raw = 1'b1;
        tick(12);
        checks++;
        if (step_count !== start + 16'd5) begin errors++; $display("FAIL repeat_count: got %0d expected %0d", step_count, start + 16'd5); end
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL repeat_release: got %b expected 0", key_held); end
        repeat_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        int s;
        repeat_en = 1'b1;
        press(s);
        wait_cyc(s + 1);
        enable = 1'b0;
        tick(30);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL enable_drop_idle: got %b expected 0", key_held); end
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL enable_drop_count: got %0d expected %0d", step_count, exp_count); end
        key_raw = 1'b1;
        tick(8);
        enable    = 1'b1;
        repeat_en = 1'b0;
        tick(4);
    endtask

    task automatic test_wrap_reset();
        int s;
        force dut.step_cnt_q = 16'hFFFF;
        tick(1);
        release dut.step_cnt_q;
        exp_count = 16'hFFFF;
        tick(1);
        checks++;
        if (step_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0d expected 65535", step_count); end
        press(s);
        wait_cyc(s + 1);
        checks++;
        if (step_count !== 16'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", step_count); end
        reset_n = 1'b0;
        key_raw = 1'b1;
        tick(1);
        reset_n   = 1'b1;
        exp_count = 16'd0;
        checks++;
        if (manual_clock !== 1'b0) begin errors++; $display("FAIL reset_mid_phase: got %b expected 0", manual_clock); end
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL reset_mid_held: got %b expected 0", key_held); end
        tick(10);
        checks++;
        if (step_count !== exp_count) begin errors++; $display("FAIL reset_mid_count: got %0d expected %0d", step_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_enable_drop();
        test_wrap_reset();
        tick(4);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_steps: got %0d pending expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
